// File: rtl/submod_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : submod_arbiter_if
// Brief    : Requester-side and shared-resource-side signal bundle for submod_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface submod_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_timeout;
    logic                      busy;
    logic                      sub_req;
    logic [DATA_W-1:0]         sub_data_in;
    logic [DATA_W-1:0]         sub_data_out;
    logic                      sub_valid;

    // master: the arbiter; slave: requesters plus the shared submod instance
    modport master (
        input  req_valid, req_data, sub_data_out, sub_valid,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, busy, sub_req, sub_data_in
    );

    modport slave (
        output req_valid, req_data, sub_data_out, sub_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, busy, sub_req, sub_data_in
    );
endinterface
`default_nettype wire

// File: rtl/submod_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : submod_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one submod between NUM_REQ
//            requesters. Optional WAIT timeout under SUBMOD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module submod_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    submod_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("submod_arbiter: NUM_REQ or TIMEOUT out of range");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                busy_q, busy_d;
    logic                sub_req_q, sub_req_d;
    logic [DATA_W-1:0]   sub_data_in_q, sub_data_in_d;

    logic                any_req;
    logic [IDX_W-1:0]    pick;
    logic [DATA_W-1:0]   pick_data;
    logic                timeout_hit;
    int                  idx;

    // Scan offsets from high to low so the lowest offset from rr_ptr wins.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[IDX_W'(idx)]) begin
                any_req = 1'b1;
                pick    = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == IDX_W'(j)) begin
                pick_data = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SUBMOD_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT && !bus.sub_valid && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        rsp_timeout_d = 1'b0;
        busy_d        = busy_q;
        sub_req_d     = 1'b0;
        sub_data_in_d = sub_data_in_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d            = S_ISSUE;
                    winner_d           = pick;
                    sub_data_in_d      = pick_data;
                    req_ready_d[pick]  = 1'b1;
                    sub_req_d          = 1'b1;
                    busy_d             = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT;
                rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
            end
            S_WAIT: begin
                if (bus.sub_valid) begin
                    state_d               = S_RESP;
                    rsp_valid_d[winner_q] = 1'b1;
                    rsp_data_d            = bus.sub_data_out;
                end else if (timeout_hit) begin
                    state_d               = S_RESP;
                    rsp_valid_d[winner_q] = 1'b1;
                    rsp_timeout_d         = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            sub_req_q     <= 1'b0;
            sub_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            sub_req_q     <= sub_req_d;
            sub_data_in_q <= sub_data_in_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;
    assign bus.sub_req     = sub_req_q;
    assign bus.sub_data_in = sub_data_in_q;

endmodule
`default_nettype wire
